// File: rtl/axi_mgr_sequencer.sv
// axi_mgr_sequencer: round-robin, single-outstanding AXI4 manager transaction controller.
// Sequences the AW/W/AR TX wrappers, consumes the B/R RX wrappers and enforces a per-transaction timeout.
`default_nettype none

module axi_mgr_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          resp_valid,
  output logic [1:0]          resp_code,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_timeout,
  output logic                busy,
  output logic                owner,
  output logic                aw_tx_en,
  output logic                w_tx_en,
  output logic                ar_tx_en,
  output logic [ADDR_W-1:0]   aw_tx_data,
  output logic [DATA_W-1:0]   w_tx_data,
  output logic [ADDR_W-1:0]   ar_tx_data,
  input  logic                aw_tx_hold,
  input  logic                w_tx_hold,
  input  logic                ar_tx_hold,
  input  logic [1:0]          b_rx_data,
  input  logic                b_new_data,
  input  logic [DATA_W-1:0]   r_rx_data,
  input  logic                r_new_data
);

  typedef enum logic [2:0] {
    IDLE, WR_ISSUE, WR_WAIT, WAIT_B, RD_ISSUE, WAIT_AR, WAIT_R, RESP
  } state_t;

  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  state_t              state, state_n;
  logic                last;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [15:0]         cnt;
  logic                aw_done, w_done, b_got, r_got;
  logic [1:0]          bresp_q;
  logic [DATA_W-1:0]   rbuf_q;
  logic [1:0]          code_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                tmo_q;

  logic                grant, win, expired;
  logic                aw_ok, w_ok, b_ok, r_ok;
  logic [1:0]          b_code;
  logic [DATA_W-1:0]   r_val;
  logic                resp_load, tmo_n;
  logic [1:0]          code_n;
  logic [DATA_W-1:0]   rdata_n;

  always_comb begin
    grant = (state == IDLE) && (req_valid != 2'b00);
    win   = (req_valid == 2'b11) ? ~last : req_valid[1];
    if (grant) req_ready = win ? 2'b10 : 2'b01;
    else       req_ready = 2'b00;
  end

  // Completion may come from an event seen earlier (latched flag) or in the current cycle.
  assign expired = (cnt == TMAX);
  assign aw_ok   = aw_done | ~aw_tx_hold;
  assign w_ok    = w_done  | ~w_tx_hold;
  assign b_ok    = b_got   | b_new_data;
  assign b_code  = b_got ? bresp_q : b_rx_data;
  assign r_ok    = r_got   | r_new_data;
  assign r_val   = r_got ? rbuf_q : r_rx_data;

  always_comb begin
    state_n   = state;
    resp_load = 1'b0;
    code_n    = 2'b00;
    rdata_n   = '0;
    tmo_n     = 1'b0;
    case (state)
      IDLE:     if (grant) state_n = req_write[win] ? WR_ISSUE : RD_ISSUE;
      WR_ISSUE: state_n = WR_WAIT;
      RD_ISSUE: state_n = WAIT_AR;
      WR_WAIT: begin
        if (aw_ok && w_ok && b_ok) begin
          state_n = RESP; resp_load = 1'b1; code_n = b_code;
        end else if (expired) begin
          state_n = RESP; resp_load = 1'b1; code_n = 2'b10; tmo_n = 1'b1;
        end else if (aw_ok && w_ok) begin
          state_n = WAIT_B;
        end
      end
      WAIT_B: begin
        if (b_new_data) begin
          state_n = RESP; resp_load = 1'b1; code_n = b_rx_data;
        end else if (expired) begin
          state_n = RESP; resp_load = 1'b1; code_n = 2'b10; tmo_n = 1'b1;
        end
      end
      WAIT_AR: begin
        if (!ar_tx_hold && r_ok) begin
          state_n = RESP; resp_load = 1'b1; rdata_n = r_val;
        end else if (expired) begin
          state_n = RESP; resp_load = 1'b1; code_n = 2'b10; tmo_n = 1'b1;
        end else if (!ar_tx_hold) begin
          state_n = WAIT_R;
        end
      end
      WAIT_R: begin
        if (r_new_data) begin
          state_n = RESP; resp_load = 1'b1; rdata_n = r_rx_data;
        end else if (expired) begin
          state_n = RESP; resp_load = 1'b1; code_n = 2'b10; tmo_n = 1'b1;
        end
      end
      RESP:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      b_got   <= 1'b0;
      r_got   <= 1'b0;
      bresp_q <= 2'b00;
      rbuf_q  <= '0;
      code_q  <= 2'b00;
      rdata_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (grant) begin
        addr_q  <= win ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
        wdata_q <= win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        last    <= win;
        owner   <= win;
      end
      case (state)
        WR_ISSUE, RD_ISSUE: begin
          cnt     <= '0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          b_got   <= 1'b0;
          r_got   <= 1'b0;
        end
        WR_WAIT, WAIT_B, WAIT_AR, WAIT_R: begin
          if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        end
        default: ;
      endcase
      if (state == WR_WAIT) begin
        if (!aw_tx_hold) aw_done <= 1'b1;
        if (!w_tx_hold)  w_done  <= 1'b1;
        if (b_new_data && !b_got) begin
          b_got   <= 1'b1;
          bresp_q <= b_rx_data;
        end
      end
      if (state == WAIT_AR && r_new_data && !r_got) begin
        r_got  <= 1'b1;
        rbuf_q <= r_rx_data;
      end
      if (resp_load) begin
        code_q  <= code_n;
        rdata_q <= rdata_n;
        tmo_q   <= tmo_n;
      end
    end
  end

  assign resp_valid   = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign resp_code    = code_q;
  assign resp_rdata   = rdata_q;
  assign resp_timeout = tmo_q & (state == RESP);
  assign busy         = (state != IDLE);
  assign aw_tx_en     = (state == WR_ISSUE);
  assign w_tx_en      = (state == WR_ISSUE);
  assign ar_tx_en     = (state == RD_ISSUE);
  assign aw_tx_data   = addr_q;
  assign w_tx_data    = wdata_q;
  assign ar_tx_data   = addr_q;

endmodule

`default_nettype wire
